// File: rtl/oldland_tlb_ctrl.sv
// oldland_tlb_ctrl: fully associative software-managed TLB with lookup/load ports and invalidate-all sweep
//   clk, rst (sync, active-low)
//   enable                       : 0 selects identity mapping
//   lookup_valid/ready/virt      : lookup request, 1-cycle registered resp_* result
//   resp_valid/hit/miss/phys/access : lookup result
//   load_valid/ready/virt/phys/access : install a translation (overwrite on match, else round-robin)
//   inval_all, busy              : start / progress of the invalidate-all sweep
module oldland_tlb_ctrl #(
  parameter int ENTRIES = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        lookup_valid,
  output logic        lookup_ready,
  input  logic [31:12] lookup_virt,
  output logic        resp_valid,
  output logic        resp_hit,
  output logic        resp_miss,
  output logic [31:12] resp_phys,
  output logic [1:0]  resp_access,
  input  logic        load_valid,
  output logic        load_ready,
  input  logic [31:12] load_virt,
  input  logic [31:12] load_phys,
  input  logic [1:0]  load_access,
  input  logic        inval_all,
  output logic        busy
);
  localparam int IW = $clog2(ENTRIES);
  typedef enum logic {IDLE, SWEEP} state_t;
  state_t state;
  logic [IW-1:0] cnt, victim;
  logic [ENTRIES-1:0] valid;
  logic [31:12] virt [ENTRIES];
  logic [31:12] phys [ENTRIES];
  logic [1:0] access [ENTRIES];
  logic lk_hit, ld_hit, lk_go, ld_go;
  logic [IW-1:0] lk_idx, ld_idx, ld_slot;
  assign lookup_ready = state == IDLE;
  assign load_ready = state == IDLE;
  assign lk_go = lookup_valid & lookup_ready;
  assign ld_go = load_valid & load_ready;
  assign ld_slot = ld_hit ? ld_idx : victim;
  // descending scan so the lowest matching index is the one kept
  always_comb begin
    lk_hit = 1'b0;
    lk_idx = '0;
    ld_hit = 1'b0;
    ld_idx = '0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (valid[i] && virt[i] == lookup_virt) begin
        lk_hit = 1'b1;
        lk_idx = IW'(i);
      end
      if (valid[i] && virt[i] == load_virt) begin
        ld_hit = 1'b1;
        ld_idx = IW'(i);
      end
    end
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      cnt <= '0;
      victim <= '0;
      valid <= '0;
      busy <= 1'b0;
    end else if (state == IDLE) begin
      if (ld_go) begin
        valid[ld_slot] <= 1'b1;
        victim <= ld_hit ? victim : victim + 1'b1;
      end
      if (inval_all) begin
        state <= SWEEP;
        cnt <= '0;
        busy <= 1'b1;
      end
    end else begin
      valid[cnt] <= 1'b0;
      cnt <= inval_all ? '0 : cnt + 1'b1;
      if (!inval_all && cnt == IW'(ENTRIES - 1)) begin
        state <= IDLE;
        busy <= 1'b0;
        victim <= '0;
      end
    end
  end
  // payload storage carries no reset; validity alone gates its use
  always_ff @(posedge clk) begin
    if (ld_go) begin
      virt[ld_slot] <= load_virt;
      phys[ld_slot] <= load_phys;
      access[ld_slot] <= load_access;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      resp_valid <= 1'b0;
      resp_hit <= 1'b0;
      resp_miss <= 1'b0;
      resp_phys <= '0;
      resp_access <= '0;
    end else begin
      resp_valid <= lk_go;
      resp_hit <= lk_go & (!enable | lk_hit);
      resp_miss <= lk_go & enable & !lk_hit;
      if (lk_go) begin
        resp_phys <= !enable ? lookup_virt : lk_hit ? phys[lk_idx] : '0;
        resp_access <= !enable ? 2'b11 : lk_hit ? access[lk_idx] : 2'b00;
      end
    end
  end
endmodule
